// File: rtl/regfile_ctrl_if.sv
// regfile_ctrl_if: request/response handshake bundle between an upstream client and the register-file controller
interface regfile_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/regfile_ctrl.sv
// regfile_ctrl: zero-fills a synchronous register file after reset, then serialises read/write requests onto it
module regfile_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_,
    regfile_ctrl_if.slave     bus,
    output logic              init_done,
    output logic              rf_we_,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_din,
    input  logic [DATA_W-1:0] rf_dout
);
    typedef enum logic [2:0] {INIT, IDLE, WRITE, READ, CAPTURE, RSP} state_t;
    localparam logic [ADDR_W-1:0] LAST = '1;
    state_t            state, state_d;
    logic [ADDR_W-1:0] cnt, cnt_d, rf_addr_d;
    logic [DATA_W-1:0] rf_din_d, rsp_rdata_d;
    logic              rf_we_d, req_ready_d, rsp_valid_d, init_done_d;
    // next state and next registered outputs; the sweep ends once the write to LAST has been presented
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        rf_we_d     = rf_we_;
        rf_addr_d   = rf_addr;
        rf_din_d    = rf_din;
        req_ready_d = bus.req_ready;
        rsp_valid_d = bus.rsp_valid;
        rsp_rdata_d = bus.rsp_rdata;
        init_done_d = init_done;
        case (state)
            INIT: begin
                if (!rf_we_ && rf_addr == LAST) begin
                    state_d     = IDLE;
                    rf_we_d     = 1'b1;
                    req_ready_d = 1'b1;
                    init_done_d = 1'b1;
                end else begin
                    rf_we_d   = 1'b0;
                    rf_addr_d = cnt;
                    rf_din_d  = '0;
                    cnt_d     = (cnt == LAST) ? cnt : cnt + 1'b1;
                end
            end
            IDLE: begin
                if (bus.req_valid) begin
                    state_d     = bus.req_write ? WRITE : READ;
                    req_ready_d = 1'b0;
                    rf_addr_d   = bus.req_addr;
                    rf_we_d     = !bus.req_write;
                    rf_din_d    = bus.req_write ? bus.req_wdata : rf_din;
                end
            end
            WRITE: begin
                state_d     = IDLE;
                rf_we_d     = 1'b1;
                req_ready_d = 1'b1;
            end
            READ: state_d = CAPTURE;
            CAPTURE: begin
                state_d     = RSP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = rf_dout;
            end
            RSP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: state_d = INIT;
        endcase
    end
    // state and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_) begin
            state         <= INIT;
            cnt           <= '0;
            rf_we_        <= 1'b1;
            rf_addr       <= '0;
            rf_din        <= '0;
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            init_done     <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            rf_we_        <= rf_we_d;
            rf_addr       <= rf_addr_d;
            rf_din        <= rf_din_d;
            bus.req_ready <= req_ready_d;
            bus.rsp_valid <= rsp_valid_d;
            bus.rsp_rdata <= rsp_rdata_d;
            init_done     <= init_done_d;
        end
    end
endmodule
